// File: rtl/univ_shift_seq_if.sv
// Command channel into the shift-register sequencer.
// A command transfers on the rising edge where cmd_valid && cmd_ready; payload is sampled only then.
interface univ_shift_seq_if #(
  parameter int DW = 4,
  parameter int CW = 3
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [DW-1:0] cmd_data;
  logic [CW-1:0] cmd_cnt;
  logic          cmd_fill;
  logic          cmd_rot;

  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_cnt, cmd_fill, cmd_rot,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_cnt, cmd_fill, cmd_rot,
    output cmd_ready
  );
endinterface

// File: rtl/univ_shift_seq.sv
// Sequencer driving a universal 4-mode shift register one command at a time,
// with a shadow copy of the downstream q kept in step every cycle.
module univ_shift_seq #(
  parameter int DW = 4,
  parameter int CW = 3
) (
  input  logic           clk,
  input  logic           async_rst_n,
  univ_shift_seq_if.slave cmd,
  output logic [1:0]     ctrl,
  output logic [DW-1:0]  data,
  output logic           data_l,
  output logic           data_h,
  output logic [DW-1:0]  q_model,
  output logic           busy,
  output logic           done,
  output logic [1:0]     o_dbg_state
);
  localparam logic [1:0] CTRL_LOAD = 2'b00;
  localparam logic [1:0] CTRL_SHL  = 2'b10;
  localparam logic [1:0] CTRL_SHR  = 2'b01;
  localparam logic [1:0] CTRL_HOLD = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        r_state, w_state_nx;
  logic [1:0]    r_ctrl, w_ctrl_nx;
  logic [DW-1:0] r_data, w_data_nx;
  logic [DW-1:0] r_q, w_q_nx;
  logic          r_done, w_done_nx;
  logic [CW-1:0] r_count, w_count_nx;
  logic          r_fill, w_fill_nx;
  logic          r_rot, w_rot_nx;
  logic          w_data_l, w_data_h;

  // Serial inputs: in rotate mode feed back the bit that falls off the other end.
  assign w_data_l = r_rot ? r_q[DW-1] : r_fill;
  assign w_data_h = r_rot ? r_q[0]    : r_fill;

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      r_state <= S_IDLE;
      r_ctrl  <= CTRL_HOLD;
      r_data  <= '0;
      r_q     <= '0;
      r_done  <= 1'b0;
      r_count <= '0;
      r_fill  <= 1'b0;
      r_rot   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_ctrl  <= w_ctrl_nx;
      r_data  <= w_data_nx;
      r_q     <= w_q_nx;
      r_done  <= w_done_nx;
      r_count <= w_count_nx;
      r_fill  <= w_fill_nx;
      r_rot   <= w_rot_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_ctrl_nx  = r_ctrl;
    w_data_nx  = r_data;
    w_done_nx  = 1'b0;
    w_count_nx = r_count;
    w_fill_nx  = r_fill;
    w_rot_nx   = r_rot;
    case (r_state)
      S_IDLE: begin
        if (cmd.cmd_valid) begin
          w_fill_nx = cmd.cmd_fill;
          w_rot_nx  = cmd.cmd_rot;
          case (cmd.cmd_op)
            2'b00: begin
              w_state_nx = S_LOAD;
              w_ctrl_nx  = CTRL_LOAD;
              w_data_nx  = cmd.cmd_data;
            end
            2'b01, 2'b10: begin
              if (cmd.cmd_cnt != '0) begin
                w_state_nx = S_SHIFT;
                w_ctrl_nx  = (cmd.cmd_op == 2'b10) ? CTRL_SHL : CTRL_SHR;
                w_count_nx = cmd.cmd_cnt;
              end else begin
                w_state_nx = S_DONE;
                w_done_nx  = 1'b1;
              end
            end
            default: begin
              // Reserved op behaves as a zero-length shift.
              w_state_nx = S_DONE;
              w_done_nx  = 1'b1;
            end
          endcase
        end
      end
      S_LOAD: begin
        w_state_nx = S_DONE;
        w_ctrl_nx  = CTRL_HOLD;
        w_done_nx  = 1'b1;
      end
      S_SHIFT: begin
        w_count_nx = r_count - CW'(1);
        if (r_count == CW'(1)) begin
          w_state_nx = S_DONE;
          w_ctrl_nx  = CTRL_HOLD;
          w_done_nx  = 1'b1;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  // Mirror of the downstream register's update so q_model tracks q exactly.
  always_comb begin
    w_q_nx = r_q;
    case (r_ctrl)
      CTRL_LOAD: w_q_nx = r_data;
      CTRL_SHL:  w_q_nx = {r_q[DW-2:0], w_data_l};
      CTRL_SHR:  w_q_nx = {w_data_h, r_q[DW-1:1]};
      default:   w_q_nx = r_q;
    endcase
  end

  assign cmd.cmd_ready = (r_state == S_IDLE);
  assign busy          = (r_state != S_IDLE);
  assign ctrl          = r_ctrl;
  assign data          = r_data;
  assign data_l        = w_data_l;
  assign data_h        = w_data_h;
  assign q_model       = r_q;
  assign done          = r_done;
  assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_univ_shift_seq.sv
// Bench for univ_shift_seq: directed scenarios plus random commands, checked
// against a word-level reference model and a downstream shift register.
module tb_univ_shift_seq;
  localparam int DW = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          async_rst_n = 1'b0;
  logic [1:0]    ctrl;
  logic [DW-1:0] data;
  logic          data_l, data_h;
  logic [DW-1:0] q_model;
  logic          busy, done;
  logic [1:0]    dbg_state;
  logic [DW-1:0] q;

  int n_cmp = 0;
  int n_bad = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] m_q = '0;

  // ---------------- clock / reset / DUT ----------------
  always #5 clk = ~clk;

  univ_shift_seq_if #(.DW(DW), .CW(CW)) cmd_if ();

  univ_shift_seq #(.DW(DW), .CW(CW)) dut (
    .clk         (clk),
    .async_rst_n (async_rst_n),
    .cmd         (cmd_if.slave),
    .ctrl        (ctrl),
    .data        (data),
    .data_l      (data_l),
    .data_h      (data_h),
    .q_model     (q_model),
    .busy        (busy),
    .done        (done),
    .o_dbg_state (dbg_state)
  );

  // Downstream universal shift register.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) q <= '0;
    else begin
      case (ctrl)
        2'b00:   q <= data;
        2'b10:   q <= {q[DW-2:0], data_l};
        2'b01:   q <= {data_h, q[DW-1:1]};
        default: q <= q;
      endcase
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) check("q_vs_shadow", 32'(q), 32'(q_model));

  // ---------------- reference model ----------------
  function automatic logic [DW-1:0] ref_final(input logic [DW-1:0] q0, input logic [1:0] op,
                                              input logic [DW-1:0] d, input int n,
                                              input bit fill, input bit rot);
    int mask, v, r;
    mask = (1 << DW) - 1;
    v = int'(q0);
    if (op == 2'b00) return d;
    if (op == 2'b11 || n == 0) return q0;
    if (rot) begin
      r = n % DW;
      if (op == 2'b10) v = (v << r) | (v >> (DW - r));
      else             v = (v >> r) | (v << (DW - r));
    end else if (n >= DW) begin
      v = fill ? mask : 0;
    end else if (op == 2'b10) begin
      v = (v << n) | (fill ? ((1 << n) - 1) : 0);
    end else begin
      v = (v >> n) | (fill ? (mask & ~(mask >> n)) : 0);
    end
    return DW'(v & mask);
  endfunction

  function automatic logic [DW-1:0] ref_step(input logic [DW-1:0] v, input bit left,
                                             input bit fill, input bit rot);
    bit in_bit;
    in_bit = rot ? (left ? v[DW-1] : v[0]) : fill;
    return left ? {v[DW-2:0], in_bit} : {in_bit, v[DW-1:1]};
  endfunction

  // ---------------- driver ----------------
  task automatic drive_fields(input logic [1:0] op, input logic [DW-1:0] d, input int n,
                              input bit fill, input bit rot);
    cmd_if.cmd_op   = op;
    cmd_if.cmd_data = d;
    cmd_if.cmd_cnt  = CW'(n);
    cmd_if.cmd_fill = fill;
    cmd_if.cmd_rot  = rot;
  endtask

  task automatic scramble_fields();
    drive_fields(2'($urandom_range(0, 3)), DW'($urandom_range(0, 15)),
                 $urandom_range(0, 7), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [DW-1:0] d, input int n,
                         input bit fill, input bit rot, input bit hold);
    int t, k, n_eff, exp_cycles, dones;
    bit left, ser_exp;
    logic [1:0] code, exp_ctrl;
    logic [DW-1:0] q_exp;
    left  = (op == 2'b10);
    code  = left ? 2'b10 : 2'b01;
    n_eff = (op == 2'b01 || op == 2'b10) ? n : 0;
    exp_cycles = (op == 2'b00) ? 3 : ((n_eff > 0) ? n_eff + 2 : 2);
    t = 0;
    while (!cmd_if.cmd_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("ready_before_cmd", 32'(cmd_if.cmd_ready), 1);
    exp_q.push_back(ref_final(m_q, op, d, n, fill, rot));
    drive_fields(op, d, n, fill, rot);
    cmd_if.cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold) cmd_if.cmd_valid = 1'b0;
    scramble_fields();
    q_exp = m_q;
    k = 1;
    dones = 0;
    while (!cmd_if.cmd_ready && k <= 40) begin
      exp_ctrl = (op == 2'b00 && k == 1) ? 2'b00 : ((k <= n_eff) ? code : 2'b11);
      check("ctrl", 32'(ctrl), 32'(exp_ctrl));
      check("q_model_step", 32'(q_model), 32'(q_exp));
      check("busy", 32'(busy), 1);
      if (exp_ctrl == 2'b00) begin
        check("load_data", 32'(data), 32'(d));
        q_exp = d;
      end else if (exp_ctrl == code) begin
        ser_exp = rot ? (left ? q_exp[DW-1] : q_exp[0]) : fill;
        check("serial_in", 32'(left ? data_l : data_h), 32'(ser_exp));
        q_exp = ref_step(q_exp, left, fill, rot);
      end
      if (done) begin
        dones++;
        if (exp_q.size() > 0) check("done_result", 32'(q_model), 32'(exp_q.pop_front()));
        else check("done_unexpected", 32'(done), 0);
      end
      @(negedge clk);
      k++;
    end
    cmd_if.cmd_valid = 1'b0;
    m_q = ref_final(m_q, op, d, n, fill, rot);
    check("cmd_cycles", 32'(k), 32'(exp_cycles));
    check("done_count", 32'(dones), 1);
    check("final_q", 32'(q_model), 32'(m_q));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_if.cmd_valid = 1'b0;
    drive_fields(2'b00, '0, 0, 1'b0, 1'b0);
    #12;
    check("rst_ctrl", 32'(ctrl), 32'(2'b11));
    check("rst_data", 32'(data), 0);
    check("rst_q_model", 32'(q_model), 0);
    check("rst_done", 32'(done), 0);
    check("rst_ready", 32'(cmd_if.cmd_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_state", 32'(dbg_state), 0);
    check("rst_serial", 32'({data_l, data_h}), 0);
    @(negedge clk);
    async_rst_n = 1'b1;
    @(negedge clk);

    run_cmd(2'b00, 4'b1011, 0, 1'b0, 1'b0, 1'b0);
    run_cmd(2'b10, '0, 2, 1'b0, 1'b0, 1'b0);
    check("shl2_result", 32'(q_model), 32'(4'b1100));
    run_cmd(2'b00, 4'b1001, 0, 1'b0, 1'b0, 1'b0);
    run_cmd(2'b01, '0, 3, 1'b0, 1'b1, 1'b0);
    check("shr3_rot_result", 32'(q_model), 32'(4'b0011));
    run_cmd(2'b10, '0, 0, 1'b1, 1'b0, 1'b0);
    run_cmd(2'b11, '0, 5, 1'b1, 1'b0, 1'b0);
    run_cmd(2'b00, 4'b0000, 0, 1'b0, 1'b0, 1'b0);
    run_cmd(2'b01, '0, 6, 1'b1, 1'b0, 1'b1);
    check("shr6_fill_result", 32'(q_model), 32'(4'b1111));

    // Reset in the middle of a long shift.
    run_cmd(2'b00, 4'b1010, 0, 1'b0, 1'b0, 1'b0);
    drive_fields(2'b10, '0, 5, 1'b1, 1'b0);
    cmd_if.cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_if.cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_reset_q", 32'(q_model), 32'(4'b1011));
    #1 async_rst_n = 1'b0;
    #1;
    check("mid_rst_ctrl", 32'(ctrl), 32'(2'b11));
    check("mid_rst_q_model", 32'(q_model), 0);
    check("mid_rst_q", 32'(q), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_done", 32'(done), 0);
    #2 async_rst_n = 1'b1;
    m_q = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_no_done", 32'(done), 0);
      check("post_rst_ctrl", 32'(ctrl), 32'(2'b11));
    end
    run_cmd(2'b00, 4'b0101, 0, 1'b0, 1'b0, 1'b0);
    check("post_rst_load", 32'(q_model), 32'(4'b0101));

    for (int i = 0; i < 40; i++) begin
      run_cmd(2'($urandom_range(0, 3)), DW'($urandom_range(0, 15)), $urandom_range(0, 7),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    end
    check("scoreboard_empty", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/univ_shift_seq.md
Name: univ_shift_seq

Overview:
- Command sequencer that sits directly upstream of the universal 4-mode shift register and drives its ctrl, data, data_l and data_h inputs.
- Accepts one command at a time over a valid/ready handshake: parallel load, shift-left by N, or shift-right by N, each with a constant fill bit or rotate.
- Keeps a shadow copy (q_model) that equals the downstream register's q every cycle, for the consumer and the bench.

Parameters:
- DW, 4, data width; must match the downstream shift register.
- CW, 3, width of the shift-count field; counts 0..2**CW-1 are legal.

Ports:
- clk  in  1  rising-edge clock, shared with the downstream register.
- async_rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command; high only in IDLE.
- cmd_op  in  2  00 LOAD, 01 SHR, 10 SHL, 11 reserved (treated as SHR with count 0).
- cmd_data  in  DW  parallel word for LOAD.
- cmd_cnt  in  CW  number of shift steps for SHR/SHL.
- cmd_fill  in  1  serial fill bit when cmd_rot=0.
- cmd_rot  in  1  1 = rotate: fill bit is the bit being shifted out.
- ctrl  out  2  to shift register: 00 load, 10 shift left (data_l→LSB), 01 shift right (data_h→MSB), 11 hold.
- data  out  DW  to shift register parallel input.
- data_l  out  1  to shift register LSB serial input.
- data_h  out  1  to shift register MSB serial input.
- q_model  out  DW  shadow of the downstream q.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a command completes.

Behaviour:
- Reset (async, while async_rst_n=0), regardless of state:
  - state=IDLE, ctrl=11, data=0, q_model=0, done=0, count=0, fill_r=0, rot_r=0.
  - cmd_ready=1, busy=0.
  - Reset mid-command aborts immediately; ctrl returns to hold asynchronously.
- States: IDLE, LOAD, SHIFT, DONE.
- Registered outputs: ctrl, data, q_model, done. Combinational outputs: cmd_ready=(state==IDLE), busy=!cmd_ready.
- Serial outputs (combinational):
  - data_l = rot_r ? q_model[DW-1] : fill_r
  - data_h = rot_r ? q_model[0] : fill_r
- Accept edge E0 (IDLE and cmd_valid): latch fill_r, rot_r, dir.
  - LOAD: state→LOAD, ctrl→00, data→cmd_data.
  - SHL/SHR with cmd_cnt≥1: state→SHIFT, ctrl→10 or 01, count→cmd_cnt.
  - SHL/SHR with cmd_cnt=0, or op 11: state→DONE, ctrl stays 11, done→1.
- LOAD, one cycle: next edge → DONE, ctrl→11, done→1.
- SHIFT: each edge decrements count.
  - When count==1 at the edge: → DONE, ctrl→11, done→1.
  - Otherwise ctrl is unchanged.
  - Exactly cmd_cnt cycles carry a shift ctrl.
  - Counts greater than DW are legal; the word is fully replaced by fill bits, or rotated modulo DW.
- DONE: done=1 for exactly one cycle; next edge → IDLE, done→0.
  - cmd_ready stays low in DONE, so commands are never back-to-back.
  - Minimum period: LOAD 3 cycles; SHIFT N+2 cycles.
- q_model update, at every edge, using the current registered ctrl/data and combinational data_l/data_h:
  - 00: q_model ← data.
  - 10: q_model ← {q_model[DW-2:0], data_l}.
  - 01: q_model ← {data_h, q_model[DW-1:1]}.
  - 11: q_model holds.
  - This is the same update the downstream register applies, so q_model==q after every edge.
- cmd_valid while not IDLE is ignored; inputs are not sampled and nothing is queued.
- Inputs are sampled only at the accept edge; later changes to cmd_* do not affect the running command.

Test Plan:
- Reset, then LOAD cmd_data=4'b1011 → ctrl=00 for exactly one cycle, data=1011, then ctrl=11; done pulses one cycle after the LOAD cycle; q_model=1011.
- After loading 1011, SHL cnt=2 fill=0 rot=0 → exactly two ctrl=10 cycles with data_l=0; q_model 0110 then 1100; done once; cmd_ready returns high the cycle after done.
- After loading 1001, SHR cnt=3 rot=1 → three ctrl=01 cycles; data_h follows q_model[0]; q_model 1100, 0110, 0011.
- SHL cnt=0 → no cycle with ctrl≠11; done pulses at the edge after accept; q_model unchanged.
- SHR cnt=6 fill=1 from 0000 → six ctrl=01 cycles; q_model=1111. Holding cmd_valid high throughout must not start a second command before IDLE.
- Drop async_rst_n for 3 ns during a SHL cnt=5 after the second shift → ctrl=11, q_model=0, busy=0 immediately; no done pulse; after release, a new LOAD 0101 completes normally.
- All scenarios: instantiate the downstream shift register and check q==q_model every cycle.
